// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/exception controller feeding the next-PC unit.
//
// Collects synchronous exceptions from EX (illegal instruction, ecall) and a
// periodic timer interrupt, prioritises them (illegal > ecall > timer), raises
// a zero-latency redirect request and tracks the exception level between
// handler entry and handler return.
//
// State table:
//   state   | meaning
//   IDLE    | normal execution; requests are visible and may redirect
//   HANDLER | handler running (EXL_Set=1); all requests masked
//
// Ports:
//   clk              in   clock, all state updates on posedge
//   rst              in   asynchronous active-high reset
//   PCWrite          in   PC update enable; redirect/return accepted only when 1
//   NPCOp            in   next-PC op from EX; NPC_INT_RET marks handler return
//   illegal_instr_EX in   EX-stage instruction is illegal (level)
//   ecall_EX         in   EX-stage instruction is ecall (level)
//   timer_en         in   enables timer counting and timer interrupt delivery
//   INT_Signal       out  redirect request to the NPC
//   INT_PEND         out  winning cause code, 0 when no request
//   EXL_Set          out  exception level, 1 while the handler runs
//   SCAUSE           out  cause latched at handler entry
//   int_count        out  number of accepted redirects (wraps)
//   double_fault     out  sticky: synchronous exception seen while EXL_Set=1
//
// The cause/op encodings are parameters so they can be aligned with the shared
// control encoding definitions of the core.

module int_ctrl #(
    parameter int          TIMER_PERIOD      = 1000,
    parameter int          TIMER_W           = 32,
    parameter int          COUNT_W           = 16,
    parameter logic [2:0]  NPC_INT_RET       = 3'b101,
    parameter logic [2:0]  INT_TIMER         = 3'd1,
    parameter logic [2:0]  INT_ILLEGAL_INSTR = 3'd2,
    parameter logic [2:0]  INT_ECALL         = 3'd3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic [2:0]         NPCOp,
    input  logic               illegal_instr_EX,
    input  logic               ecall_EX,
    input  logic               timer_en,
    output logic               INT_Signal,
    output logic [2:0]         INT_PEND,
    output logic               EXL_Set,
    output logic [2:0]         SCAUSE,
    output logic [COUNT_W-1:0] int_count,
    output logic               double_fault
);

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_PERIOD - 1);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer_cnt;
    logic               timer_pending;
    logic               timer_wrap;
    logic               accept;
    logic               ret;
    logic               fault;

    assign timer_wrap = timer_en && (timer_cnt == TIMER_LAST);

    always_comb begin
        state_nxt  = state;
        INT_Signal = 1'b0;
        INT_PEND   = 3'd0;
        accept     = 1'b0;
        ret        = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: begin
                if (illegal_instr_EX) begin
                    INT_Signal = 1'b1;
                    INT_PEND   = INT_ILLEGAL_INSTR;
                end else if (ecall_EX) begin
                    INT_Signal = 1'b1;
                    INT_PEND   = INT_ECALL;
                end else if (timer_pending && timer_en) begin
                    INT_Signal = 1'b1;
                    INT_PEND   = INT_TIMER;
                end
                accept = INT_Signal && PCWrite;
                if (accept)
                    state_nxt = HANDLER;
            end
            HANDLER: begin
                fault = PCWrite && (illegal_instr_EX || ecall_EX);
                ret   = PCWrite && (NPCOp == NPC_INT_RET);
                if (ret)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            SCAUSE       <= 3'd0;
            int_count    <= '0;
            double_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                SCAUSE    <= INT_PEND;
                int_count <= int_count + 1'b1;
            end
            if (fault)
                double_fault <= 1'b1;
        end
    end

    // A wrap in the same cycle as a timer accept is a fresh event, so the
    // set takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_cnt     <= '0;
            timer_pending <= 1'b0;
        end else begin
            if (timer_en)
                timer_cnt <= timer_wrap ? '0 : timer_cnt + 1'b1;
            if (timer_wrap)
                timer_pending <= 1'b1;
            else if (accept && (INT_PEND == INT_TIMER))
                timer_pending <= 1'b0;
        end
    end

    assign EXL_Set = (state == HANDLER);

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt/exception controller: the source end of the INT_Signal / INT_PEND / EXL_Set interface consumed by the next-PC unit.
- Collects synchronous exceptions from EX (illegal instruction, ecall) and a periodic timer interrupt, then prioritises them.
- Drives the redirect request and tracks exception level across handler entry and handler return (NPC_INT_RET).
- Sits beside the NPC and hazard unit; shares encodings from ctrl_encode_def.v.

Parameters:
- TIMER_PERIOD, 1000: cycles between timer events; legal range ≥2.
- TIMER_W, 32: timer counter width.
- COUNT_W, 16: width of the taken-interrupt counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  PC update enable from the hazard unit; a redirect or return is accepted only in a cycle where this is 1.
- NPCOp  in  3  next-PC op from EX; the value `NPC_INT_RET marks a handler return.
- illegal_instr_EX  in  1  EX-stage instruction is illegal; level, held by the pipeline while stalled.
- ecall_EX  in  1  EX-stage instruction is ecall; level, held while stalled.
- timer_en  in  1  enables timer counting and timer interrupt delivery.
- INT_Signal  out  1  redirect request to the NPC.
- INT_PEND  out  3  cause code: `int_timer, `int_illegal_instr or `int_ecall.
- EXL_Set  out  1  exception level; 1 while the handler runs.
- SCAUSE  out  3  cause latched at handler entry.
- int_count  out  COUNT_W  number of accepted redirects; wraps modulo 2^COUNT_W.
- double_fault  out  1  sticky flag: a synchronous exception occurred while EXL_Set=1.

Behaviour:
Reset (async, immediate, any state, including mid-handler):
- State IDLE; EXL_Set=0, SCAUSE=0, int_count=0, double_fault=0.
- Timer counter=0, timer_pending=0.
- INT_Signal=0 and INT_PEND=0 as a consequence of the cleared state.

Timer:
- When timer_en=1, the counter increments each cycle.
- At TIMER_PERIOD-1 it wraps to 0 and sets timer_pending (sticky).
- When timer_en=0, the counter holds and timer_pending is retained.

Request logic (combinational, same cycle):
- In IDLE: req_ill=illegal_instr_EX, req_ec=ecall_EX, req_tm=timer_pending&timer_en.
- INT_Signal = IDLE & (req_ill|req_ec|req_tm).
- Priority: illegal > ecall > timer. INT_PEND is the winning code; 0 when INT_Signal=0.
- In HANDLER: INT_Signal=0 and INT_PEND=0; all requests are masked.

FSM (2 states):
- IDLE→HANDLER at posedge when INT_Signal & PCWrite (accept). On accept:
  - EXL_Set←1, SCAUSE←INT_PEND, int_count←int_count+1.
  - If the winner is the timer, timer_pending←0. If a wrap occurs in the same cycle, pending stays 1 (the new event wins).
- If INT_Signal=1 and PCWrite=0: hold state; INT_Signal stays asserted while the request persists. Zero-latency redirect: the NPC captures SEPC in the accept cycle.
- HANDLER→IDLE at posedge when NPCOp==`NPC_INT_RET & PCWrite; EXL_Set←0. SCAUSE is retained.
- NPC_INT_RET in IDLE: no effect.
- HANDLER with illegal_instr_EX|ecall_EX (and PCWrite=1): double_fault←1, no redirect. Cleared only by rst.
- Return and timer wrap in the same cycle: return completes with pending=1, so INT_Signal=1 in the next cycle (IDLE).
- Timer events during HANDLER stay pending. Multiple wraps collapse into one pending event.

Test Plan:
- Reset, TIMER_PERIOD=4, timer_en=1, PCWrite=1 → INT_Signal=1 with INT_PEND=`int_timer in cycle 4 after reset release; EXL_Set=1 and int_count=1 in cycle 5; timer_pending=0.
- IDLE, illegal_instr_EX=1 and ecall_EX=1 together with timer pending → INT_PEND=`int_illegal_instr; after accept SCAUSE=`int_illegal_instr and timer_pending still 1.
- ecall_EX=1 with PCWrite=0 for 3 cycles, then PCWrite=1 → INT_Signal high all 4 cycles, EXL_Set stays 0 until after the 4th cycle, int_count +1 exactly once.
- In HANDLER: timer wrap, then NPCOp=`NPC_INT_RET with PCWrite=1 → EXL_Set=0 next cycle, INT_Signal=1 immediately in IDLE with `int_timer.
- In HANDLER with ecall_EX=1 → double_fault=1, INT_Signal=0, state unchanged; NPC_INT_RET in IDLE → EXL_Set stays 0.
- Assert rst mid-HANDLER with timer_pending=1 → all outputs 0 asynchronously (before the next edge), counter restarts from 0.
